// File: rtl/id_ex_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg_if
// Purpose  : Bundles the decode-side inputs, the EX-side registered outputs,
//            the stall/flush controls and the hazard/monitor outputs of the
//            ID->EX pipeline register into one interface.
// Modports : master - decode stage / control side (drives ID_*, stall, flush;
//                     observes EX_*, load_use_hazard, bubble_count)
//            slave  - the pipeline register itself
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 3,
  parameter int IMM_W   = 8,
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 1,
  parameter int CNT_W   = 16
) ();

  // decode side
  logic               ID_valid;
  logic               stall;
  logic               flush;
  logic [OPC_W-1:0]   ID_opcode;
  logic               ID_regwrite;
  logic               ID_memtoreg;
  logic               ID_memread;
  logic               ID_memwrite;
  logic               ID_alusrc;
  logic               ID_regdist;
  logic [ALUOP_W-1:0] ID_aluop;
  logic               ID_uses_rt;
  logic [IMM_W-1:0]   ID_immediate;
  logic [REG_AW-1:0]  ID_rs;
  logic [REG_AW-1:0]  ID_rt;
  logic [REG_AW-1:0]  ID_rd;
  logic [DATA_W-1:0]  ID_rd1;
  logic [DATA_W-1:0]  ID_rd2;

  // execute side
  logic               EX_valid;
  logic [OPC_W-1:0]   EX_opcode;
  logic               EX_regwrite;
  logic               EX_memtoreg;
  logic               EX_memread;
  logic               EX_memwrite;
  logic               EX_alusrc;
  logic               EX_regdist;
  logic [ALUOP_W-1:0] EX_aluop;
  logic [IMM_W-1:0]   EX_immediate;
  logic [REG_AW-1:0]  EX_rs;
  logic [REG_AW-1:0]  EX_rt;
  logic [REG_AW-1:0]  EX_rd;
  logic [DATA_W-1:0]  EX_rd1;
  logic [DATA_W-1:0]  EX_rd2;

  logic               load_use_hazard;
  logic [CNT_W-1:0]   bubble_count;

  modport master (
    output ID_valid, stall, flush, ID_opcode, ID_regwrite, ID_memtoreg,
           ID_memread, ID_memwrite, ID_alusrc, ID_regdist, ID_aluop,
           ID_uses_rt, ID_immediate, ID_rs, ID_rt, ID_rd, ID_rd1, ID_rd2,
    input  EX_valid, EX_opcode, EX_regwrite, EX_memtoreg, EX_memread,
           EX_memwrite, EX_alusrc, EX_regdist, EX_aluop, EX_immediate,
           EX_rs, EX_rt, EX_rd, EX_rd1, EX_rd2, load_use_hazard, bubble_count
  );

  modport slave (
    input  ID_valid, stall, flush, ID_opcode, ID_regwrite, ID_memtoreg,
           ID_memread, ID_memwrite, ID_alusrc, ID_regdist, ID_aluop,
           ID_uses_rt, ID_immediate, ID_rs, ID_rt, ID_rd, ID_rd1, ID_rd2,
    output EX_valid, EX_opcode, EX_regwrite, EX_memtoreg, EX_memread,
           EX_memwrite, EX_alusrc, EX_regdist, EX_aluop, EX_immediate,
           EX_rs, EX_rt, EX_rd, EX_rd1, EX_rd2, load_use_hazard, bubble_count
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Purpose  : ID->EX pipeline register with valid bit, external stall/flush,
//            built-in load-use hazard detection with automatic bubble
//            insertion and a saturating bubble counter.
// Ports    : clk  - pipeline clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - id_ex_pipe_reg_if.slave: ID_* in, EX_* out, stall, flush,
//                   load_use_hazard (combinational), bubble_count
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 3,
  parameter int IMM_W        = 8,
  parameter int OPC_W        = 5,
  parameter int ALUOP_W      = 1,
  parameter int CNT_W        = 16,
  parameter int R0_HARDWIRED = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  id_ex_pipe_reg_if.slave    bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Whole EX-side state in one record so a bubble/reset is a single clear.
  typedef struct packed {
    logic               valid;
    logic [OPC_W-1:0]   opcode;
    logic               regwrite;
    logic               memtoreg;
    logic               memread;
    logic               memwrite;
    logic               alusrc;
    logic               regdist;
    logic [ALUOP_W-1:0] aluop;
    logic [IMM_W-1:0]   immediate;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
  } ex_state_t;

  ex_state_t         r_ex;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic [REG_AW-1:0] w_ex_dst;
  logic              w_dst_match;
  logic              w_dst_ok;
  logic              w_hazard;
  logic              w_bubble;
  logic              w_load;

  // Destination register of the instruction currently in EX.
  assign w_ex_dst    = r_ex.regdist ? r_ex.rd : r_ex.rt;
  assign w_dst_match = (w_ex_dst == bus.ID_rs) |
                       (bus.ID_uses_rt & (w_ex_dst == bus.ID_rt));

  generate
    if (R0_HARDWIRED != 0) begin : g_r0_filter
      // Loads to r0 are discarded, so they can never feed a dependant.
      assign w_dst_ok = (w_ex_dst != '0);
    end else begin : g_r0_plain
      assign w_dst_ok = 1'b1;
    end
  endgenerate

  assign w_hazard = r_ex.valid & r_ex.memread & bus.ID_valid & w_dst_match & w_dst_ok;

  // Flush wins over stall; stall suppresses the hazard bubble (the hazard is
  // simply re-evaluated once the stall lifts).
  assign w_bubble = bus.flush | (~bus.stall & w_hazard);
  assign w_load   = ~bus.flush & ~bus.stall & ~w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex         <= '0;
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_ex <= '0;
      if (r_bubble_cnt != C_CNT_MAX) begin
        r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
      end
    end else if (w_load) begin
      r_ex.valid     <= bus.ID_valid;
      r_ex.opcode    <= bus.ID_opcode;
      r_ex.regwrite  <= bus.ID_regwrite;
      r_ex.memtoreg  <= bus.ID_memtoreg;
      r_ex.memread   <= bus.ID_memread;
      r_ex.memwrite  <= bus.ID_memwrite;
      r_ex.alusrc    <= bus.ID_alusrc;
      r_ex.regdist   <= bus.ID_regdist;
      r_ex.aluop     <= bus.ID_aluop;
      r_ex.immediate <= bus.ID_immediate;
      r_ex.rs        <= bus.ID_rs;
      r_ex.rt        <= bus.ID_rt;
      r_ex.rd        <= bus.ID_rd;
      r_ex.rd1       <= bus.ID_rd1;
      r_ex.rd2       <= bus.ID_rd2;
    end
  end

  assign bus.EX_valid        = r_ex.valid;
  assign bus.EX_opcode       = r_ex.opcode;
  assign bus.EX_regwrite     = r_ex.regwrite;
  assign bus.EX_memtoreg     = r_ex.memtoreg;
  assign bus.EX_memread      = r_ex.memread;
  assign bus.EX_memwrite     = r_ex.memwrite;
  assign bus.EX_alusrc       = r_ex.alusrc;
  assign bus.EX_regdist      = r_ex.regdist;
  assign bus.EX_aluop        = r_ex.aluop;
  assign bus.EX_immediate    = r_ex.immediate;
  assign bus.EX_rs           = r_ex.rs;
  assign bus.EX_rt           = r_ex.rt;
  assign bus.EX_rd           = r_ex.rd;
  assign bus.EX_rd1          = r_ex.rd1;
  assign bus.EX_rd2          = r_ex.rd2;
  assign bus.load_use_hazard = w_hazard;
  assign bus.bubble_count    = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Purpose  : Self-checking bench for id_ex_pipe_reg: reset, a directed vector
//            table, a mid-stream reset, randomized traffic against a
//            behavioural model, and counter saturation on a narrow instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic       valid;
    logic [4:0] opcode;
    logic       regwrite, memtoreg, memread, memwrite, alusrc, regdist;
    logic [0:0] aluop;
    logic       uses_rt;
    logic [7:0] imm;
    logic [2:0] rs, rt, rd;
    logic [31:0] rd1, rd2;
  } instr_t;

  typedef struct {
    logic v; logic [4:0] opc; logic mr, rdist, urt;
    logic [2:0] rs, rt, rd; logic [31:0] rd1; logic st, fl;
    logic e_haz, e_valid; logic [4:0] e_opc; logic [31:0] e_rd1;
    logic e_mr; int e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.CNT_W(2))  bus_s ();

  id_ex_pipe_reg #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  id_ex_pipe_reg #(.CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t i, input logic st, input logic fl);
    bus.ID_valid = i.valid;       bus.ID_opcode = i.opcode;
    bus.ID_regwrite = i.regwrite; bus.ID_memtoreg = i.memtoreg;
    bus.ID_memread = i.memread;   bus.ID_memwrite = i.memwrite;
    bus.ID_alusrc = i.alusrc;     bus.ID_regdist = i.regdist;
    bus.ID_aluop = i.aluop;       bus.ID_uses_rt = i.uses_rt;
    bus.ID_immediate = i.imm;     bus.ID_rs = i.rs;
    bus.ID_rt = i.rt;             bus.ID_rd = i.rd;
    bus.ID_rd1 = i.rd1;           bus.ID_rd2 = i.rd2;
    bus.stall = st;               bus.flush = fl;
  endtask

  function automatic instr_t sample();
    instr_t s;
    s.valid = bus.EX_valid;       s.opcode = bus.EX_opcode;
    s.regwrite = bus.EX_regwrite; s.memtoreg = bus.EX_memtoreg;
    s.memread = bus.EX_memread;   s.memwrite = bus.EX_memwrite;
    s.alusrc = bus.EX_alusrc;     s.regdist = bus.EX_regdist;
    s.aluop = bus.EX_aluop;       s.uses_rt = 1'b0;
    s.imm = bus.EX_immediate;     s.rs = bus.EX_rs;
    s.rt = bus.EX_rt;             s.rd = bus.EX_rd;
    s.rd1 = bus.EX_rd1;           s.rd2 = bus.EX_rd2;
    return s;
  endfunction

  function automatic vec_t mk(input logic v, input logic [4:0] opc, input logic mr,
                              input logic rdist, input logic urt, input logic [2:0] rs,
                              input logic [2:0] rt, input logic [2:0] rd,
                              input logic [31:0] rd1, input logic st, input logic fl,
                              input logic e_haz, input logic e_valid, input logic [4:0] e_opc,
                              input logic [31:0] e_rd1, input logic e_mr, input int e_cnt);
    vec_t r;
    r.v = v; r.opc = opc; r.mr = mr; r.rdist = rdist; r.urt = urt;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rd1 = rd1; r.st = st; r.fl = fl;
    r.e_haz = e_haz; r.e_valid = e_valid; r.e_opc = e_opc; r.e_rd1 = e_rd1;
    r.e_mr = e_mr; r.e_cnt = e_cnt;
    return r;
  endfunction

  function automatic instr_t from_vec(input vec_t r);
    instr_t i;
    i.valid = r.v; i.opcode = r.opc; i.regwrite = 1'b1; i.memtoreg = r.mr;
    i.memread = r.mr; i.memwrite = 1'b0; i.alusrc = r.mr; i.regdist = r.rdist;
    i.aluop = 1'b1; i.uses_rt = r.urt; i.imm = {3'b101, r.opc};
    i.rs = r.rs; i.rt = r.rt; i.rd = r.rd; i.rd1 = r.rd1; i.rd2 = ~r.rd1;
    return i;
  endfunction

  // ------------------------------------------------------ behavioural model
  instr_t m_ex;
  int     m_cnt;

  function automatic logic m_hazard(input instr_t ex, input instr_t id);
    logic [2:0] dst;
    dst = ex.regdist ? ex.rd : ex.rt;
    return ex.valid && ex.memread && id.valid && (dst != 3'd0) &&
           ((dst == id.rs) || (id.uses_rt && (dst == id.rt)));
  endfunction

  task automatic m_step(input instr_t id, input logic st, input logic fl);
    if (fl || (!st && m_hazard(m_ex, id))) begin
      m_ex = '0;
      if (m_cnt < 65535) m_cnt++;
    end else if (!st) begin
      m_ex = id;
      m_ex.uses_rt = 1'b0;
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid = ($urandom_range(0, 9) != 0);
    i.opcode = 5'($urandom);       i.regwrite = 1'($urandom);
    i.memtoreg = 1'($urandom);     i.memread = ($urandom_range(0, 1) == 1);
    i.memwrite = 1'($urandom);     i.alusrc = 1'($urandom);
    i.regdist = 1'($urandom);      i.aluop = 1'($urandom);
    i.uses_rt = 1'($urandom);      i.imm = 8'($urandom);
    i.rs = 3'($urandom);           i.rt = 3'($urandom);
    i.rd = 3'($urandom);           i.rd1 = $urandom;
    i.rd2 = $urandom;
    return i;
  endfunction

  // ----------------------------------------------------------------- test
  vec_t tbl[27];
  int   sat_exp[5];

  initial begin
    instr_t idle;
    instr_t ri;
    logic   rst_st, rst_fl;
    idle = '0;

    // mr rdist urt rs rt rd rd1 st fl | haz valid opc rd1 mr cnt
    tbl[0]  = mk(1,5'h0A,0,1,1,1,2,4,32'h11111111,0,0, 0,1,5'h0A,32'h11111111,0,0);
    tbl[1]  = mk(1,5'h0B,0,1,1,1,2,4,32'h22222222,0,0, 0,1,5'h0B,32'h22222222,0,0);
    tbl[2]  = mk(1,5'h0C,0,1,1,1,2,4,32'h33333333,0,0, 0,1,5'h0C,32'h33333333,0,0);
    tbl[3]  = mk(1,5'h0D,1,0,1,1,3,5,32'h44444444,0,0, 0,1,5'h0D,32'h44444444,1,0);
    tbl[4]  = mk(1,5'h0E,0,1,1,3,1,2,32'h55555555,0,0, 1,0,5'h00,32'h00000000,0,1);
    tbl[5]  = mk(1,5'h0E,0,1,1,3,1,2,32'h55555555,0,0, 0,1,5'h0E,32'h55555555,0,1);
    tbl[6]  = mk(1,5'h10,1,0,1,1,0,6,32'h66666666,0,0, 0,1,5'h10,32'h66666666,1,1);
    tbl[7]  = mk(1,5'h11,0,1,1,0,0,1,32'h12121212,0,0, 0,1,5'h11,32'h12121212,0,1);
    tbl[8]  = mk(1,5'h12,1,0,1,1,5,7,32'h13131313,0,0, 0,1,5'h12,32'h13131313,1,1);
    tbl[9]  = mk(1,5'h13,0,1,0,2,5,1,32'h14141414,0,0, 0,1,5'h13,32'h14141414,0,1);
    tbl[10] = mk(1,5'h14,1,1,1,1,2,6,32'h15151515,0,0, 0,1,5'h14,32'h15151515,1,1);
    tbl[11] = mk(1,5'h15,1,1,1,1,2,6,32'h16161616,0,0, 0,1,5'h15,32'h16161616,1,1);
    tbl[12] = mk(1,5'h16,0,1,1,6,1,2,32'h17171717,0,0, 1,0,5'h00,32'h00000000,0,2);
    tbl[13] = mk(1,5'h16,0,1,1,6,1,2,32'h17171717,0,0, 0,1,5'h16,32'h17171717,0,2);
    tbl[14] = mk(1,5'h17,0,1,1,1,2,4,32'h18181818,1,1, 0,0,5'h00,32'h00000000,0,3);
    tbl[15] = mk(1,5'h18,0,1,1,1,2,4,32'h88888888,0,0, 0,1,5'h18,32'h88888888,0,3);
    tbl[16] = mk(1,5'h19,0,1,1,1,2,4,32'h99999999,1,0, 0,1,5'h18,32'h88888888,0,3);
    tbl[17] = mk(1,5'h19,0,1,1,1,2,4,32'h99999999,1,0, 0,1,5'h18,32'h88888888,0,3);
    tbl[18] = mk(1,5'h19,0,1,1,1,2,4,32'h99999999,1,0, 0,1,5'h18,32'h88888888,0,3);
    tbl[19] = mk(1,5'h1A,1,0,1,1,4,5,32'hAAAAAAAA,0,0, 0,1,5'h1A,32'hAAAAAAAA,1,3);
    tbl[20] = mk(1,5'h1B,0,1,1,4,1,2,32'hBBBBBBBB,1,0, 1,1,5'h1A,32'hAAAAAAAA,1,3);
    tbl[21] = mk(1,5'h1B,0,1,1,4,1,2,32'hBBBBBBBB,0,0, 1,0,5'h00,32'h00000000,0,4);
    tbl[22] = mk(1,5'h1B,0,1,1,4,1,2,32'hBBBBBBBB,0,0, 0,1,5'h1B,32'hBBBBBBBB,0,4);
    tbl[23] = mk(0,5'h1C,0,1,1,1,2,4,32'h77777777,0,0, 0,0,5'h1C,32'h77777777,0,4);
    tbl[24] = mk(1,5'h1D,1,0,1,1,3,5,32'hCCCCCCCC,0,0, 0,1,5'h1D,32'hCCCCCCCC,1,4);
    tbl[25] = mk(1,5'h1E,0,1,1,3,1,2,32'hDDDDDDDD,0,1, 1,0,5'h00,32'h00000000,0,5);
    tbl[26] = mk(1,5'h1E,0,1,1,3,1,2,32'hDDDDDDDD,0,0, 0,1,5'h1E,32'hDDDDDDDD,0,5);
    sat_exp = '{1, 2, 3, 3, 3};

    // ---------------- reset state
    rst = 1'b1;
    drive(idle, 1'b0, 1'b0);
    bus_s.ID_valid = 0; bus_s.stall = 0; bus_s.flush = 0; bus_s.ID_opcode = '0;
    bus_s.ID_regwrite = 0; bus_s.ID_memtoreg = 0; bus_s.ID_memread = 0;
    bus_s.ID_memwrite = 0; bus_s.ID_alusrc = 0; bus_s.ID_regdist = 0;
    bus_s.ID_aluop = '0; bus_s.ID_uses_rt = 0; bus_s.ID_immediate = '0;
    bus_s.ID_rs = '0; bus_s.ID_rt = '0; bus_s.ID_rd = '0;
    bus_s.ID_rd1 = '0; bus_s.ID_rd2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 128'(sample()), 128'(0));
    chk("reset_count", 128'(bus.bubble_count), 128'(0));
    chk("reset_hazard", 128'(bus.load_use_hazard), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // ---------------- directed vector table
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      drive(from_vec(tbl[k]), tbl[k].st, tbl[k].fl);
      #1;
      chk($sformatf("tbl%0d_hazard", k), 128'(bus.load_use_hazard), 128'(tbl[k].e_haz));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", k), 128'(bus.EX_valid), 128'(tbl[k].e_valid));
      chk($sformatf("tbl%0d_opcode", k), 128'(bus.EX_opcode), 128'(tbl[k].e_opc));
      chk($sformatf("tbl%0d_rd1", k), 128'(bus.EX_rd1), 128'(tbl[k].e_rd1));
      chk($sformatf("tbl%0d_memread", k), 128'(bus.EX_memread), 128'(tbl[k].e_mr));
      chk($sformatf("tbl%0d_count", k), 128'(bus.bubble_count), 128'(tbl[k].e_cnt));
    end

    // ---------------- asynchronous reset mid-stream
    @(negedge clk);
    ri = '0;
    ri.valid = 1'b1; ri.regwrite = 1'b1; ri.opcode = 5'h07; ri.rd1 = 32'hDEAD_BEEF;
    drive(ri, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_load_regwrite", 128'(bus.EX_regwrite), 128'(1));
    chk("mid_load_rd1", 128'(bus.EX_rd1), 128'(32'hDEAD_BEEF));
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_state", 128'(sample()), 128'(0));
    chk("mid_reset_count", 128'(bus.bubble_count), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    ri.uses_rt = 1'b0;
    chk("post_reset_load", 128'(sample()), 128'(ri));
    chk("post_reset_count", 128'(bus.bubble_count), 128'(0));

    // ---------------- randomized traffic against the model
    @(negedge clk);
    drive(idle, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ex = '0;
    m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ri = rand_instr();
      rst_st = ($urandom_range(0, 99) < 15);
      rst_fl = ($urandom_range(0, 99) < 10);
      drive(ri, rst_st, rst_fl);
      #1;
      chk($sformatf("rnd%0d_hazard", n), 128'(bus.load_use_hazard), 128'(m_hazard(m_ex, ri)));
      m_step(ri, rst_st, rst_fl);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_ex", n), 128'(sample()), 128'(m_ex));
      chk($sformatf("rnd%0d_count", n), 128'(bus.bubble_count), 128'(m_cnt));
    end

    // ---------------- saturation on the 2-bit counter instance
    @(negedge clk);
    drive(idle, 1'b0, 1'b0);
    chk("sat_start", 128'(bus_s.bubble_count), 128'(0));
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      bus_s.flush = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("sat_flush%0d", s), 128'(bus_s.bubble_count), 128'(sat_exp[s]));
    end
    @(negedge clk);
    bus_s.flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised next-generation ID→EX pipeline register for the 19-bit CPU pipeline.
- Adds the following over a plain latch:
  - asynchronous reset;
  - a valid bit;
  - external stall (hold) and flush (bubble);
  - built-in load-use hazard detection with automatic bubble insertion;
  - a saturating bubble counter for performance monitoring.
- Sits between the decode stage and the EX/ALU stage.
- Its hazard output drives the PC/IF-ID hold logic.

Parameters:
- DATA_W, 32, width of register-file read data ID_rd1/ID_rd2.
- REG_AW, 3, register address width (rs/rt/rd).
- IMM_W, 8, immediate field width.
- OPC_W, 5, opcode width.
- ALUOP_W, 1, ALU operation control width.
- CNT_W, 16, bubble counter width.
- R0_HARDWIRED, 1, if 1, register address 0 never creates a hazard.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_valid  in  1  decode stage holds a real instruction.
- stall  in  1  external hold request (e.g. memory wait); freezes this register.
- flush  in  1  external squash (branch taken/exception); inserts a bubble.
- ID_opcode  in  OPC_W  decoded opcode.
- ID_regwrite, ID_memtoreg, ID_memread, ID_memwrite, ID_alusrc, ID_regdist  in  1 each  decode control bits.
- ID_aluop  in  ALUOP_W  ALU control.
- ID_uses_rt  in  1  instruction reads rt as a source operand.
- ID_immediate  in  IMM_W  immediate.
- ID_rs, ID_rt, ID_rd  in  REG_AW each  register addresses.
- ID_rd1, ID_rd2  in  DATA_W each  register read data.
- EX_valid  out  1  EX stage holds a real instruction.
- EX_opcode … EX_rd2  out  same widths as the ID_ fields  registered copies of every ID_ field above, except ID_uses_rt, which is not forwarded.
- load_use_hazard  out  1  combinational; asks upstream stages to hold the current ID instruction.
- bubble_count  out  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset (async, rst=1): all EX_* outputs = 0, EX_valid = 0, bubble_count = 0, immediately and independent of clk. Reset release takes effect at the next rising edge.
- Destination of the EX instruction: ex_dst = EX_regdist ? EX_rd : EX_rt.
- load_use_hazard = EX_valid & EX_memread & ID_valid & (ex_dst==ID_rs | (ID_uses_rt & ex_dst==ID_rt)).
  - When R0_HARDWIRED=1, the term is forced to 0 if ex_dst==0.
  - Purely combinational from current EX state and ID inputs; no latency.
- Per-edge update, priority highest first:
  1. flush=1: bubble.
  2. stall=1: hold; all EX_* and bubble_count unchanged.
  3. load_use_hazard=1: bubble.
  4. Otherwise: load all ID_* into EX_*; EX_valid <= ID_valid.
- Bubble definition:
  - EX_valid <= 0.
  - EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc, EX_regdist <= 0; EX_aluop <= 0; EX_opcode <= 0.
  - Data/address/immediate fields are cleared to 0, so bubbles are deterministic.
  - A bubble never writes registers or memory downstream.
- bubble_count:
  - +1 on every edge where a bubble is inserted (flush, or hazard without stall).
  - Saturates at 2^CNT_W−1 and never wraps.
  - Unchanged on hold or normal load.
- Simultaneous events:
  - flush+stall → bubble; flush wins.
  - stall+hazard → hold, no count; the hazard re-evaluates next cycle.
  - flush+hazard → a single bubble, counted once.
- Hazard self-clears one cycle after the bubble, because EX_valid=0 removes the load from EX. This gives exactly one bubble per load-use pair.
- ID_valid=0 with no flush/stall/hazard: fields are loaded as presented, but EX_valid=0; bubble_count does not increment.
- No combinational path from ID_* to EX_* outputs; register latency is 1 cycle.
- No $display or other simulation-only side effects in the synthesizable body.

Test Plan:
- Reset mid-stream: load a valid instruction (EX_regwrite=1, EX_rd1=32'hDEAD_BEEF), assert rst between edges → all outputs 0 immediately; bubble_count=0; the first edge after release loads normally.
- Plain pipelining: 4 back-to-back valid instructions, no stall/flush → each EX_* equals the prior-cycle ID_* (e.g. ID_opcode=5'h0A appears on EX_opcode 1 cycle later); bubble_count stays 0.
- Load-use: EX holds a load (memread=1, regdist=0, EX_rt=3); ID has ID_rs=3 → load_use_hazard=1 the same cycle. Next edge: EX_valid=0, controls 0, bubble_count=1, hazard drops. The following edge loads the held ID instruction.
- Hazard filters:
  - R0_HARDWIRED=1, load to r0 with ID_rs=0 → no hazard.
  - ID_uses_rt=0, ID_rt matches ex_dst, ID_rs does not → no hazard.
  - ex_dst=EX_rd when EX_regdist=1 → the hazard follows rd.
- Priority: stall=1 with flush=1 → bubble, count+1. Stall alone for 3 cycles → EX outputs frozen, count unchanged. Stall plus active hazard → frozen, count unchanged; release stall → bubble, count+1.
- Saturation: CNT_W=2, 5 consecutive flushes → bubble_count sequence 1,2,3,3,3.
